// File: rtl/ethernet_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ethernet_pkg
//  Brief    : Shared constants and FSM encoding for the Ethernet TX MMIO path.
//  Revision : 1.0
// ============================================================================
package ethernet_pkg;

    localparam int          c_eth_mtu_default    = 2048;
    localparam logic [13:0] c_tx_buf_base        = 14'h1000;
    localparam logic [13:0] c_tx_send_addr       = 14'h0820;
    localparam logic [13:0] c_tx_size_addr       = 14'h0828;
    localparam logic [13:0] c_tx_status_addr     = 14'h0830;
    localparam int          c_tx_status_free_bit = 0;

    typedef logic [3:0] state_t;

    localparam state_t c_st_idle      = 4'd0;
    localparam state_t c_st_poll      = 4'd1;
    localparam state_t c_st_poll_wait = 4'd2;
    localparam state_t c_st_backoff   = 4'd3;
    localparam state_t c_st_stream    = 4'd4;
    localparam state_t c_st_drain     = 4'd5;
    localparam state_t c_st_size      = 4'd6;
    localparam state_t c_st_send      = 4'd7;
    localparam state_t c_st_done      = 4'd8;
    localparam state_t c_st_err       = 4'd9;

endpackage
`default_nettype wire

// File: rtl/ethernet_popcount_keep.sv
`default_nettype none
// ============================================================================
//  Module   : ethernet_popcount_keep
//  Brief    : Combinational count of set byte-valid lanes in a tkeep vector.
//  Revision : 1.0
// ============================================================================
module ethernet_popcount_keep #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]             i_keep,
    output logic [$clog2(WIDTH+1)-1:0]   o_count
);

    localparam int c_cw = $clog2(WIDTH + 1);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_count = o_count + c_cw'(i_keep[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ethernet_tx_mmio_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : ethernet_tx_mmio_initiator
//  Brief    : Streams one frame into the controller TX buffer over MMIO, then
//             writes the byte size and the send strobe.
//  Revision : 1.0
// ============================================================================
module ethernet_tx_mmio_initiator
    import ethernet_pkg::*;
#(
    parameter int          DATA_WIDTH     = 32,
    parameter int          ETH_MTU        = c_eth_mtu_default,
    parameter logic [13:0] TX_BUF_BASE    = c_tx_buf_base,
    parameter logic [13:0] TX_SEND_ADDR   = c_tx_send_addr,
    parameter logic [13:0] TX_SIZE_ADDR   = c_tx_size_addr,
    parameter logic [13:0] TX_STATUS_ADDR = c_tx_status_addr,
    parameter int          POLL_INTERVAL  = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [DATA_WIDTH-1:0]   s_tdata_i,
    input  logic [DATA_WIDTH/8-1:0] s_tkeep_i,
    input  logic                    s_tvalid_i,
    input  logic                    s_tlast_i,
    output logic                    s_tready_o,
    output logic [13:0]             addr_o,
    output logic                    write_en_o,
    output logic                    read_en_o,
    output logic [DATA_WIDTH/8-1:0] write_mask_o,
    output logic [DATA_WIDTH-1:0]   write_data_o,
    input  logic [DATA_WIDTH-1:0]   read_data_i,
    output logic                    done_o,
    output logic                    error_o
);

    localparam int c_bpw = DATA_WIDTH / 8;
    localparam int c_bcw = $clog2(ETH_MTU + 1);
    localparam int c_iw  = $clog2(ETH_MTU / c_bpw);
    localparam int c_sw  = c_bcw + 1;
    localparam int c_pw  = $clog2(POLL_INTERVAL + 1);
    localparam int c_kw  = $clog2(c_bpw + 1);

    state_t            r_state;
    state_t            w_next;
    logic [c_iw-1:0]   r_idx;
    logic [c_bcw-1:0]  r_bytes;
    logic [c_pw-1:0]   r_backoff;
    logic [c_kw-1:0]   w_pop;
    logic [c_sw-1:0]   w_sum;
    logic              w_over;
    logic [13:0]       w_buf_addr;
    logic              w_unused;

    ethernet_popcount_keep #(
        .WIDTH (c_bpw)
    ) u_popcount (
        .i_keep  (s_tkeep_i),
        .o_count (w_pop)
    );

    // One spare bit on the sum so an overshoot past the MTU is always visible.
    assign w_sum      = {1'b0, r_bytes} + c_sw'(w_pop);
    assign w_over     = w_sum > c_sw'(ETH_MTU);
    assign w_buf_addr = TX_BUF_BASE + 14'(r_idx * c_bpw);
    assign w_unused   = ^read_data_i[DATA_WIDTH-1:1];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_idx     <= '0;
            r_bytes   <= '0;
            r_backoff <= '0;
        end else begin
            case (r_state)
                c_st_poll_wait: begin
                    r_idx     <= '0;
                    r_bytes   <= '0;
                    r_backoff <= '0;
                end
                c_st_backoff: r_backoff <= r_backoff + 1'b1;
                c_st_stream: begin
                    if (s_tvalid_i && !w_over) begin
                        r_idx   <= r_idx + 1'b1;
                        r_bytes <= w_sum[c_bcw-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle:      if (s_tvalid_i) w_next = c_st_poll;
            c_st_poll:      w_next = c_st_poll_wait;
            c_st_poll_wait: w_next = read_data_i[c_tx_status_free_bit] ? c_st_stream : c_st_backoff;
            c_st_backoff:   if (r_backoff == c_pw'(POLL_INTERVAL - 1)) w_next = c_st_poll;
            c_st_stream: begin
                if (s_tvalid_i) begin
                    if (w_over) begin
                        w_next = s_tlast_i ? c_st_err : c_st_drain;
                    end else if (s_tlast_i) begin
                        w_next = (w_sum != '0) ? c_st_size : c_st_err;
                    end
                end
            end
            c_st_drain:     if (s_tvalid_i && s_tlast_i) w_next = c_st_err;
            c_st_size:      w_next = c_st_send;
            c_st_send:      w_next = c_st_done;
            c_st_done:      w_next = c_st_idle;
            c_st_err:       w_next = c_st_idle;
            default:        w_next = c_st_idle;
        endcase
    end

    always_comb begin
        s_tready_o   = 1'b0;
        addr_o       = '0;
        write_en_o   = 1'b0;
        read_en_o    = 1'b0;
        write_mask_o = '0;
        write_data_o = '0;
        done_o       = 1'b0;
        error_o      = 1'b0;
        case (r_state)
            c_st_poll: begin
                read_en_o = 1'b1;
                addr_o    = TX_STATUS_ADDR;
            end
            c_st_stream: begin
                s_tready_o = 1'b1;
                // Write goes out in the same cycle as the handshake.
                if (s_tvalid_i && !w_over) begin
                    write_en_o   = 1'b1;
                    addr_o       = w_buf_addr;
                    write_mask_o = s_tkeep_i;
                    write_data_o = s_tdata_i;
                end
            end
            c_st_drain: s_tready_o = 1'b1;
            c_st_size: begin
                write_en_o   = 1'b1;
                addr_o       = TX_SIZE_ADDR;
                write_mask_o = '1;
                write_data_o = DATA_WIDTH'(r_bytes);
            end
            c_st_send: begin
                write_en_o   = 1'b1;
                addr_o       = TX_SEND_ADDR;
                write_mask_o = '1;
                write_data_o = DATA_WIDTH'(1);
            end
            c_st_done: done_o  = 1'b1;
            c_st_err:  error_o = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire
